// File: rtl/control_fsm_pkg.sv
// rtl/control_fsm_pkg.sv - shared opcodes, state encoding, immediate and ALU codes for control_fsm
package control_fsm_pkg;

  // Instruction opcodes, Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  // Controller states
  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_BR  = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_WB_MEM   = 4'd10
  } state_t;

  // Immediate extension modes
  localparam logic [1:0] IMM_SEXT      = 2'b00;
  localparam logic [1:0] IMM_ZEXT      = 2'b01;
  localparam logic [1:0] IMM_HI16      = 2'b10;
  localparam logic [1:0] IMM_SEXT_SHL2 = 2'b11;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

endpackage

// File: rtl/ctrl_opdecode.sv
// rtl/ctrl_opdecode.sv - combinational opcode classifier and datapath steering decode
module ctrl_opdecode
  import control_fsm_pkg::*;
#(
  parameter logic [3:0] ADD_FUNC = ALU_ADD,
  parameter logic [3:0] SUB_FUNC = ALU_SUB
) (
  input  logic [5:0] opcode,
  input  logic [3:0] func,
  output logic       is_r,
  output logic       is_imm,
  output logic       is_br,
  output logic       is_load,
  output logic       is_store,
  output logic       is_illegal,
  output logic       br_always,
  output logic       br_if_zero,
  output logic       br_if_nonzero,
  output logic       rf_b_sel,
  output logic       alu_bin_sel,
  output logic [1:0] immed_ctrl,
  output logic [3:0] alu_func,
  output logic       rf_wrdata_sel,
  output logic       byte_op
);

  // Classify the opcode and derive steering; unknown opcodes fall to illegal with all-zero steering
  always_comb begin
    is_r          = 1'b0;
    is_imm        = 1'b0;
    is_br         = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    is_illegal    = 1'b0;
    br_always     = 1'b0;
    br_if_zero    = 1'b0;
    br_if_nonzero = 1'b0;
    rf_b_sel      = 1'b0;
    alu_bin_sel   = 1'b0;
    immed_ctrl    = IMM_SEXT;
    alu_func      = ADD_FUNC;
    rf_wrdata_sel = 1'b0;
    byte_op       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_r     = 1'b1;
        alu_func = func;
      end
      // li and lui behave as addi; the datapath forces RF_A to zero for them
      OP_LI, OP_ADDI: begin
        is_imm      = 1'b1;
        alu_bin_sel = 1'b1;
      end
      OP_LUI: begin
        is_imm      = 1'b1;
        alu_bin_sel = 1'b1;
        immed_ctrl  = IMM_HI16;
      end
      OP_ANDI: begin
        is_imm      = 1'b1;
        alu_bin_sel = 1'b1;
        immed_ctrl  = IMM_ZEXT;
        alu_func    = ALU_AND;
      end
      OP_ORI: begin
        is_imm      = 1'b1;
        alu_bin_sel = 1'b1;
        immed_ctrl  = IMM_ZEXT;
        alu_func    = ALU_OR;
      end
      OP_B, OP_BEQ, OP_BNE: begin
        is_br         = 1'b1;
        rf_b_sel      = 1'b1;
        immed_ctrl    = IMM_SEXT_SHL2;
        alu_func      = SUB_FUNC;
        br_always     = (opcode == OP_B);
        br_if_zero    = (opcode == OP_BEQ);
        br_if_nonzero = (opcode == OP_BNE);
      end
      OP_LB, OP_LW: begin
        is_load       = 1'b1;
        alu_bin_sel   = 1'b1;
        rf_wrdata_sel = 1'b1;
        byte_op       = (opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        is_store    = 1'b1;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
        byte_op     = (opcode == OP_SB);
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle instruction sequencer driving fetch, decode, ALU and memory controls
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter logic [3:0] ADD_FUNC = 4'b0000,
  parameter logic [3:0] SUB_FUNC = 4'b0001
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic [1:0]  Immed_ctrl,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_WrEn,
  output logic        ByteOp
);

  state_t state_q;
  state_t state_d;

  logic       is_r, is_imm, is_br, is_load, is_store, is_illegal;
  logic       br_always, br_if_zero, br_if_nonzero;
  logic       dec_rf_b_sel, dec_alu_bin_sel, dec_rf_wrdata_sel, dec_byte_op;
  logic [1:0] dec_immed_ctrl;
  logic [3:0] dec_alu_func;
  logic       steer_en;
  logic       br_taken;

  // Only the opcode and the R-type function nibble steer control
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:4];

  ctrl_opdecode #(
    .ADD_FUNC (ADD_FUNC),
    .SUB_FUNC (SUB_FUNC)
  ) u_opdecode (
    .opcode        (Instr[31:26]),
    .func          (Instr[3:0]),
    .is_r          (is_r),
    .is_imm        (is_imm),
    .is_br         (is_br),
    .is_load       (is_load),
    .is_store      (is_store),
    .is_illegal    (is_illegal),
    .br_always     (br_always),
    .br_if_zero    (br_if_zero),
    .br_if_nonzero (br_if_nonzero),
    .rf_b_sel      (dec_rf_b_sel),
    .alu_bin_sel   (dec_alu_bin_sel),
    .immed_ctrl    (dec_immed_ctrl),
    .alu_func      (dec_alu_func),
    .rf_wrdata_sel (dec_rf_wrdata_sel),
    .byte_op       (dec_byte_op)
  );

  assign br_taken = br_always | (br_if_zero & ALU_zero) | (br_if_nonzero & ~ALU_zero);

  // State register; reset abandons any instruction in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and control outputs from the current state and latched instruction
  always_comb begin
    state_d       = state_q;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    MEM_WrEn      = 1'b0;
    // Instr is only valid from DECODE on, so steering stays quiet in INIT and FETCH
    steer_en      = (state_q != S_INIT) && (state_q != S_FETCH);
    RF_WrData_sel = steer_en & dec_rf_wrdata_sel;
    RF_B_sel      = steer_en & dec_rf_b_sel;
    Immed_ctrl    = steer_en ? dec_immed_ctrl : IMM_SEXT;
    ALU_Bin_sel   = steer_en & dec_alu_bin_sel;
    ALU_func      = steer_en ? dec_alu_func : 4'b0000;
    ByteOp        = steer_en & dec_byte_op;
    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        IR_LdEn = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_r) begin
          state_d = S_EXEC_R;
        end else if (is_imm) begin
          state_d = S_EXEC_I;
        end else if (is_br) begin
          state_d = S_EXEC_BR;
        end else if (is_load || is_store) begin
          state_d = S_MEM_ADDR;
        end else begin
          // Illegal opcode retires as a nop: step the PC and refetch
          PC_LdEn = is_illegal;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        state_d = S_WB_ALU;
      end
      S_EXEC_BR: begin
        PC_LdEn = 1'b1;
        PC_sel  = br_taken;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        state_d = is_load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        MEM_WrEn = 1'b1;
        PC_LdEn  = 1'b1;
        state_d  = S_FETCH;
      end
      S_WB_ALU, S_WB_MEM: begin
        RF_WrEn = 1'b1;
        PC_LdEn = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the processor datapath. Sequences every instruction through fetch, decode, execute, memory and write-back states. Drives the steering and write-enable inputs of the decode stage (`RF_WrEn`, `RF_WrData_sel`, `RF_B_sel`) and the fetch, ALU and memory stages. It consumes the latched instruction word and the ALU zero flag, so it is the initiator side of the decode stage's control interface.

## Interface
Parameters:
- `ADD_FUNC`, 4'b0000: ALU function code for address and immediate adds.
- `SUB_FUNC`, 4'b0001: ALU function code for branch compare.

Ports (clock and reset first):
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `Instr` in 32: instruction register output; stable from DECODE to the end of the instruction.
- `ALU_zero` in 1: ALU result equals zero; sampled in EXEC_BR.
- `IR_LdEn` out 1: load the instruction register.
- `PC_LdEn` out 1: load the PC.
- `PC_sel` out 1: 0 selects PC+4; 1 selects PC+4+Immed.
- `RF_WrEn` out 1: register-file write; destination is Instr[20:16].
- `RF_WrData_sel` out 1: 0 selects ALU_out; 1 selects MEM_out.
- `RF_B_sel` out 1: 0 reads Instr[15:11]; 1 reads Instr[20:16].
- `Immed_ctrl` out 2: 00 sign-extend; 01 zero-extend; 10 `<<16`; 11 sign-extend then `<<2`.
- `ALU_Bin_sel` out 1: 0 selects RF_B; 1 selects Immed.
- `ALU_func` out 4: ALU operation.
- `MEM_WrEn` out 1: data-memory write.
- `ByteOp` out 1: byte access for `lb`/`sb`.

## Operation
Opcode is Instr[31:26].

| Opcode | Instruction |
|---|---|
| 100000 | R-type |
| 111000 | li |
| 111001 | lui |
| 110000 | addi |
| 110010 | andi |
| 110011 | ori |
| 111111 | b |
| 010000 | beq |
| 010001 | bne |
| 000011 | lb |
| 001111 | lw |
| 000111 | sb |
| 011111 | sw |

Every other opcode is illegal.

States: INIT, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_BR, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM.

Transitions:
- INIT → FETCH → DECODE.
- From DECODE:
  - R-type → EXEC_R.
  - li, lui, addi, andi, ori → EXEC_I.
  - Branches → EXEC_BR.
  - Loads and stores → MEM_ADDR.
  - Illegal → FETCH.
- EXEC_R, EXEC_I → WB_ALU → FETCH.
- EXEC_BR → FETCH.
- MEM_ADDR → MEM_RD (loads) or MEM_WR (stores).
- MEM_RD → WB_MEM → FETCH.
- MEM_WR → FETCH.

Single-cycle pulses (0 everywhere else):
- `IR_LdEn` in FETCH.
- `RF_WrEn` in WB_ALU and WB_MEM.
- `MEM_WrEn` in MEM_WR.
- `PC_LdEn` in WB_ALU, WB_MEM, MEM_WR, EXEC_BR, and in DECODE when the opcode is illegal (nop).

Steering signals are held constant from DECODE to the end of the instruction, decoded from the opcode:
- `RF_B_sel` = 1 for branches and stores; 0 otherwise.
- `ALU_Bin_sel` = 1 for li, lui, addi, andi, ori, loads and stores; 0 for R-type and branches.
- `Immed_ctrl`:
  - 01 for andi and ori.
  - 10 for lui.
  - 11 for branches.
  - 00 otherwise.
- `ALU_func`:
  - Instr[3:0] for R-type.
  - 4'b0010 for andi; 4'b0011 for ori.
  - `SUB_FUNC` for branches.
  - `ADD_FUNC` otherwise.
- `RF_WrData_sel` = 1 only for lb and lw.
- `ByteOp` = 1 only for lb and sb.
- li and lui rely on the datapath zeroing RF_A; the FSM treats them as addi.

Branch resolution:
- `PC_sel` is 1 only in EXEC_BR, and only when the branch is taken.
- Taken conditions: `b` always; `beq` when `ALU_zero` = 1; `bne` when `ALU_zero` = 0.

## Timing
- Reset behaviour:
  - `Reset` sampled high forces INIT on that edge.
  - Every output is 0 in INIT.
  - The first FETCH occurs on the first edge after `Reset` is sampled low.
- Reset mid-instruction:
  - Abandons the instruction.
  - No further `RF_WrEn`, `MEM_WrEn` or `PC_LdEn` pulse is issued for it.
- Latency in cycles, including FETCH:

| Instruction class | Cycles |
|---|---|
| R-type / immediate | 4 |
| Branch | 3 |
| Load | 5 |
| Store | 4 |
| Illegal | 2 |

- Outputs are Moore-style: a function of the state register and `Instr` only. No output depends combinationally on `ALU_zero` except `PC_sel` in EXEC_BR.
- `PC_LdEn` falls in the last cycle of every instruction, so PC and IR updates never overlap.

## Structure
- Shared package holds:
  - opcode localparams;
  - state encoding (4-bit);
  - `Immed_ctrl` codes;
  - ALU function codes.
- One combinational sub-module, `ctrl_opdecode`:
  - Input: the opcode.
  - Outputs: one-hot class flags (R, IMM, BR, LOAD, STORE, ILLEGAL) plus the steering signals.
  - The FSM keeps only the state register and the next-state/pulse logic.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `IR_LdEn` = 1 exactly one cycle after release.
- R-type add (opcode 100000, func 110000) → `ALU_func` = 0000, `RF_B_sel` = 0; `RF_WrEn` and `PC_LdEn` high in cycle 4 only; `PC_sel` = 0.
- lw (001111) → `RF_WrData_sel` = 1, `ALU_Bin_sel` = 1, `Immed_ctrl` = 00; `RF_WrEn` high in cycle 5; `MEM_WrEn` never high.
- sb (000111) → `ByteOp` = 1, `RF_B_sel` = 1; `MEM_WrEn` and `PC_LdEn` high in cycle 4; `RF_WrEn` never high.
- beq with `ALU_zero` = 1, then bne with `ALU_zero` = 1 → `PC_sel` = 1 then 0 in cycle 3; `Immed_ctrl` = 11; `ALU_func` = 0001.
- Illegal opcode 000000, then `Reset` asserted in MEM_RD of an lw → nop: `PC_LdEn` in cycle 2 with no writes; reset: INIT next cycle, no `RF_WrEn` pulse.
